// File: rtl/tomasulo_exe.sv
// tomasulo_exe -- fixed-latency execution unit between the reservation
// station and the common data bus (CDB).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   iss_vld_r           issue valid from the RS (accepted only when iss_rdy)
//   iss_tag/op/a/b      destination tag, opcode (ADD/SUB/AND/XOR), operands
//   iss_rdy             credit available: unit can take an issue this cycle
//   cdb_req             result queue non-empty, request the CDB
//   cdb_gnt             arbiter grant, same cycle as cdb_req
//   cdb_vld_r/tag_r/data_r  registered one-cycle CDB broadcast
//
// Stage 0 is the issue cycle itself (combinational ALU); stages 1..LAT-1 are
// registers, so the last stage pushes into the queue at the end of cycle
// t+LAT-1. Credits cover in-flight plus queued results, so pushes never
// find the queue full and the pipeline never stalls.
module tomasulo_exe #(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 3,
  parameter int LAT       = 3,
  parameter int Q_N       = 4,
  parameter bit CHK_PROTO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_vld_r,
  input  logic [TAG_W-1:0]  iss_tag,
  input  logic [1:0]        iss_op,
  input  logic [DATA_W-1:0] iss_a,
  input  logic [DATA_W-1:0] iss_b,
  output logic              iss_rdy,
  output logic              cdb_req,
  input  logic              cdb_gnt,
  output logic              cdb_vld_r,
  output logic [TAG_W-1:0]  cdb_tag_r,
  output logic [DATA_W-1:0] cdb_data_r
);

  localparam int PW = (Q_N > 1) ? $clog2(Q_N) : 1;

  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_XOR = 2'd3} op_e;

  logic [3:0]        cnt_q, occ_q;
  logic [PW-1:0]     wr_q, rd_q;
  logic              acc, pop;
  logic [DATA_W-1:0] s0_res;
  logic              push_vld;
  logic [TAG_W-1:0]  push_tag;
  logic [DATA_W-1:0] push_res;

  logic [TAG_W-1:0]  qtag_q [Q_N];
  logic [DATA_W-1:0] qdat_q [Q_N];

  assign iss_rdy = (cnt_q != 4'(Q_N));
  assign cdb_req = (occ_q != 4'd0);
  assign acc     = iss_vld_r & iss_rdy;
  assign pop     = cdb_gnt & cdb_req;

  always_comb begin
    s0_res = '0;
    case (op_e'(iss_op))
      OP_ADD: s0_res = iss_a + iss_b;
      OP_SUB: s0_res = iss_a - iss_b;
      OP_AND: s0_res = iss_a & iss_b;
      OP_XOR: s0_res = iss_a ^ iss_b;
      default: s0_res = '0;
    endcase
  end

  if (LAT == 1) begin : g_nopipe
    assign push_vld = acc;
    assign push_tag = iss_tag;
    assign push_res = s0_res;
  end else begin : g_pipe
    logic [LAT-2:0]    vld_q;
    logic [TAG_W-1:0]  tag_q [LAT-1];
    logic [DATA_W-1:0] res_q [LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= acc;
        for (int unsigned k = 1; k < LAT - 1; k++) vld_q[k] <= vld_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      tag_q[0] <= iss_tag;
      res_q[0] <= s0_res;
      for (int unsigned k = 1; k < LAT - 1; k++) begin
        tag_q[k] <= tag_q[k-1];
        res_q[k] <= res_q[k-1];
      end
    end

    assign push_vld = vld_q[LAT-2];
    assign push_tag = tag_q[LAT-2];
    assign push_res = res_q[LAT-2];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Q_N - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_vld) begin
      qtag_q[wr_q] <= push_tag;
      qdat_q[wr_q] <= push_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      cnt_q      <= '0;
      cdb_vld_r  <= 1'b0;
      cdb_tag_r  <= '0;
      cdb_data_r <= '0;
    end else begin
      if (push_vld) wr_q <= ptr_inc(wr_q);
      if (pop)      rd_q <= ptr_inc(rd_q);
      occ_q     <= occ_q + {3'b000, push_vld} - {3'b000, pop};
      cnt_q     <= cnt_q + {3'b000, acc} - {3'b000, pop};
      cdb_vld_r <= pop;
      if (pop) begin
        cdb_tag_r  <= qtag_q[rd_q];
        cdb_data_r <= qdat_q[rd_q];
      end
    end
  end

`ifndef SYNTHESIS
  if (CHK_PROTO) begin : g_chk
    always_ff @(posedge clk) begin
      if (!rst) begin
        assert (!(iss_vld_r && !iss_rdy)) else $error("protocol: iss_vld_r while iss_rdy=0");
        assert (!(cdb_gnt && !cdb_req))   else $error("protocol: cdb_gnt while cdb_req=0");
      end
    end
  end
`endif

endmodule
